// File: rtl/mult_axi_pkg.sv
// mult_axi_pkg: register map, bit indices, response codes and channel FSM states
// shared by the AXI4-Lite front-end of the 4x4 multiplier.
package mult_axi_pkg;
    localparam int ADDR_CTRL    = 'h00;
    localparam int ADDR_OPERAND = 'h04;
    localparam int ADDR_STATUS  = 'h08;
    localparam int ADDR_RESULT  = 'h0C;
    localparam int CTRL_LOAD    = 0;
    localparam int CTRL_START   = 1;
    localparam int STAT_DONE    = 0;
    localparam int STAT_BUSY    = 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;
    function automatic logic is_mapped(input int addr);
        return addr <= ADDR_RESULT + 3;
    endfunction
endpackage

// File: rtl/mult_axi_regs.sv
// mult_axi_regs: register file, LOAD/START pulse generation and i_done rising-edge
// capture (DONE/BUSY/RESULT) behind the AXI4-Lite channel FSMs.
module mult_axi_regs
    import mult_axi_pkg::*;
#(
    parameter int C_ADDR_W  = 5,
    parameter int C_DATA_W  = 32,
    parameter int OPERAND_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [C_ADDR_W-1:0]    wr_addr,
    input  logic [C_DATA_W-1:0]    wr_data,
    input  logic [C_DATA_W/8-1:0]  wr_strb,
    input  logic [C_ADDR_W-1:0]    rd_addr,
    output logic [C_DATA_W-1:0]    rd_data,
    output logic                   load,
    output logic                   start,
    output logic [OPERAND_W-1:0]   a,
    output logic [OPERAND_W-1:0]   b,
    input  logic                   mult_done,
    input  logic [2*OPERAND_W-1:0] mult_p
);
    localparam int PW = 2 * OPERAND_W;
    logic done_q, done, busy, rise, byte0_wr, ctrl_wr, load_ok, start_ok, w1c, unused;
    logic [PW-1:0] result;
    int wr_word, rd_word;
    assign wr_word  = int'(wr_addr[C_ADDR_W-1:2]);
    assign rd_word  = int'(rd_addr[C_ADDR_W-1:2]);
    assign rise     = mult_done & ~done_q;
    assign byte0_wr = wr_en & wr_strb[0];
    assign ctrl_wr  = byte0_wr & (wr_word == ADDR_CTRL / 4);
    // Control writes are dropped entirely while the core is busy.
    assign load_ok  = ctrl_wr & wr_data[CTRL_LOAD] & ~busy;
    assign start_ok = ctrl_wr & wr_data[CTRL_START] & ~busy;
    assign w1c      = byte0_wr & (wr_word == ADDR_STATUS / 4) & wr_data[STAT_DONE];
    assign rd_data  = (rd_word == ADDR_OPERAND / 4) ? C_DATA_W'({b, a}) :
                      (rd_word == ADDR_STATUS / 4)  ? C_DATA_W'({busy, done}) :
                      (rd_word == ADDR_RESULT / 4)  ? C_DATA_W'(result) : '0;
    assign unused   = ^{wr_addr[1:0], rd_addr[1:0], wr_data[C_DATA_W-1:PW], wr_strb[C_DATA_W/8-1:1]};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            done_q <= 1'b0;
            load   <= 1'b0;
            start  <= 1'b0;
            a      <= '0;
            b      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done_q <= mult_done;
            load   <= load_ok;
            start  <= start_ok;
            if (byte0_wr && wr_word == ADDR_OPERAND / 4)
                {b, a} <= wr_data[PW-1:0];
            busy   <= start_ok ? 1'b1 : rise ? 1'b0 : busy;
            done   <= rise ? 1'b1 : (start_ok | w1c) ? 1'b0 : done;
            if (rise)
                result <= mult_p;
        end
endmodule

// File: rtl/mult_axi4lite_slave.sv
// mult_axi4lite_slave: AXI4-Lite front-end for the 4x4 multiplier (write and read FSMs).
// Define MULT_AXI_SLVERR_EN to answer unmapped offsets with SLVERR instead of OKAY.
module mult_axi4lite_slave
    import mult_axi_pkg::*;
#(
    parameter int C_ADDR_W  = 5,
    parameter int C_DATA_W  = 32,
    parameter int OPERAND_W = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [C_ADDR_W-1:0]    s_axi_awaddr,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [C_DATA_W-1:0]    s_axi_wdata,
    input  logic [C_DATA_W/8-1:0]  s_axi_wstrb,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    input  logic [C_ADDR_W-1:0]    s_axi_araddr,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [C_DATA_W-1:0]    s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic                   o_load,
    output logic                   o_start,
    output logic [OPERAND_W-1:0]   o_A,
    output logic [OPERAND_W-1:0]   o_B,
    input  logic                   i_done,
    input  logic [2*OPERAND_W-1:0] i_P
);
    wr_state_t wstate;
    rd_state_t rstate;
    logic wr_en, rd_en;
    logic [1:0] wr_resp, rd_resp;
    logic [C_DATA_W-1:0] reg_rdata;
    // Ready is combinational so a transfer is accepted the cycle its valids appear.
    assign wr_en         = i_rst_n & (wstate == W_IDLE) & s_axi_awvalid & s_axi_wvalid;
    assign rd_en         = i_rst_n & (rstate == R_IDLE) & s_axi_arvalid;
    assign s_axi_awready = wr_en;
    assign s_axi_wready  = wr_en;
    assign s_axi_arready = rd_en;
`ifdef MULT_AXI_SLVERR_EN
    assign wr_resp = is_mapped(int'(s_axi_awaddr)) ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp = is_mapped(int'(s_axi_araddr)) ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif
    mult_axi_regs #(
        .C_ADDR_W (C_ADDR_W),
        .C_DATA_W (C_DATA_W),
        .OPERAND_W(OPERAND_W)
    ) u_regs (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .wr_en    (wr_en),
        .wr_addr  (s_axi_awaddr),
        .wr_data  (s_axi_wdata),
        .wr_strb  (s_axi_wstrb),
        .rd_addr  (s_axi_araddr),
        .rd_data  (reg_rdata),
        .load     (o_load),
        .start    (o_start),
        .a        (o_A),
        .b        (o_B),
        .mult_done(i_done),
        .mult_p   (i_P)
    );
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            wstate       <= W_IDLE;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else if (wstate == W_IDLE) begin
            if (wr_en) begin
                wstate       <= W_RESP;
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_resp;
            end
        end else if (s_axi_bready) begin
            wstate       <= W_IDLE;
            s_axi_bvalid <= 1'b0;
        end
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            rstate       <= R_IDLE;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (rstate == R_IDLE) begin
            if (rd_en) begin
                rstate       <= R_DATA;
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= reg_rdata;
                s_axi_rresp  <= rd_resp;
            end
        end else if (s_axi_rready) begin
            rstate       <= R_IDLE;
            s_axi_rvalid <= 1'b0;
        end
endmodule

// File: tb/tb_mult_axi4lite_slave.sv
// tb_mult_axi4lite_slave: table-driven register accesses with a read scoreboard,
// plus hand sequences for pulses, busy, DONE collision, BREADY stall and reset.
module tb_mult_axi4lite_slave;
    localparam logic [1:0] OKAY = 2'b00;
`ifdef MULT_AXI_SLVERR_EN
    localparam logic [1:0] UNMAP = 2'b10;
`else
    localparam logic [1:0] UNMAP = 2'b00;
`endif
    logic clk = 1'b0, rst_n;
    logic [4:0] awaddr, araddr;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0] wstrb, a, b;
    logic [1:0] bresp, rresp;
    logic load, start, done;
    logic [7:0] p;
    always #5 clk = ~clk;

    mult_axi4lite_slave dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .o_load(load), .o_start(start), .o_A(a), .o_B(b), .i_done(done), .i_P(p)
    );

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
        logic [1:0]  resp;
        string       name;
    } vec_t;
    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        string       name;
    } exp_t;
    localparam int NV = 14;
    vec_t vecs[NV];
    exp_t sb[$];
    int compared = 0, mismatched = 0, load_cnt = 0, start_cnt = 0;

    always @(negedge clk) begin
        if (load) load_cnt++;
        if (start) start_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input logic is_rd, input string name);
        int n = 0;
        #1;
        while (!(is_rd ? arready : (awready && wready)) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " accept"}, 32'(n < 20), 32'd1);
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input logic set_done, input string name);
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        if (set_done) done = 1'b1;
        wait_ready(1'b0, name);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check({name, " bvalid"}, 32'(bvalid), 32'd1);
        check({name, " bresp"}, 32'(bresp), 32'(resp));
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [4:0] addr, input logic [31:0] exp, input logic [1:0] resp,
                            input string name);
        exp_t e;
        sb.push_back('{exp, resp, name});
        araddr = addr; arvalid = 1'b1;
        wait_ready(1'b1, name);
        @(posedge clk); #1;
        arvalid = 1'b0;
        check({name, " rvalid"}, 32'(rvalid), 32'd1);
        e = sb.pop_front();
        check({e.name, " rdata"}, rdata, e.data);
        check({e.name, " rresp"}, 32'(rresp), 32'(e.resp));
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int l0, s0;
        logic [3:0] ma, mb;
        vecs[0]  = '{1'b0, 5'h04, 32'h0, 4'h0, 32'h0, OKAY, "operand reset"};
        vecs[1]  = '{1'b0, 5'h08, 32'h0, 4'h0, 32'h0, OKAY, "status reset"};
        vecs[2]  = '{1'b0, 5'h0C, 32'h0, 4'h0, 32'h0, OKAY, "result reset"};
        vecs[3]  = '{1'b1, 5'h04, 32'hFF, 4'hF, 32'h0, OKAY, "operand wr ff"};
        vecs[4]  = '{1'b0, 5'h04, 32'h0, 4'h0, 32'hFF, OKAY, "operand rd ff"};
        vecs[5]  = '{1'b0, 5'h00, 32'h0, 4'h0, 32'h0, OKAY, "ctrl reads 0"};
        vecs[6]  = '{1'b1, 5'h04, 32'h12345A3C, 4'hE, 32'h0, OKAY, "operand strb masked"};
        vecs[7]  = '{1'b0, 5'h04, 32'h0, 4'h0, 32'hFF, OKAY, "operand kept"};
        vecs[8]  = '{1'b1, 5'h04, 32'hAB, 4'h1, 32'h0, OKAY, "operand byte0"};
        vecs[9]  = '{1'b0, 5'h04, 32'h0, 4'h0, 32'hAB, OKAY, "operand rd ab"};
        vecs[10] = '{1'b0, 5'h14, 32'h0, 4'h0, 32'h0, UNMAP, "unmapped rd"};
        vecs[11] = '{1'b1, 5'h18, 32'h55, 4'hF, 32'h0, UNMAP, "unmapped wr"};
        vecs[12] = '{1'b0, 5'h04, 32'h0, 4'h0, 32'hAB, OKAY, "operand after unmapped"};
        vecs[13] = '{1'b1, 5'h04, 32'hFF, 4'hF, 32'h0, OKAY, "operand wr ff again"};

        rst_n = 1'b0; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; p = '0; done = 1'b0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset handshakes", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
        check("reset pulses+operands", 32'({load, start, a, b}), 32'd0);
        check("reset rdata", rdata, 32'd0);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++)
            if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, 1'b0, vecs[i].name);
            else axi_read(vecs[i].addr, vecs[i].exp, vecs[i].resp, vecs[i].name);
        check("o_A", 32'(a), 32'd15);
        check("o_B", 32'(b), 32'd15);
        ma = a; mb = b;

        l0 = load_cnt; s0 = start_cnt;
        axi_write(5'h00, 32'h1, 4'hF, OKAY, 1'b0, "ctrl load");
        repeat (2) @(posedge clk);
        #1;
        check("load pulse cycles", 32'(load_cnt - l0), 32'd1);
        check("load no start", 32'(start_cnt - s0), 32'd0);

        s0 = start_cnt;
        axi_write(5'h00, 32'h2, 4'hF, OKAY, 1'b0, "ctrl start");
        repeat (2) @(posedge clk);
        #1;
        check("start pulse cycles", 32'(start_cnt - s0), 32'd1);
        axi_read(5'h08, 32'h2, OKAY, "status busy");
        l0 = load_cnt; s0 = start_cnt;
        axi_write(5'h00, 32'h3, 4'hF, OKAY, 1'b0, "ctrl while busy");
        repeat (2) @(posedge clk);
        #1;
        check("busy start ignored", 32'(start_cnt - s0), 32'd0);
        check("busy load ignored", 32'(load_cnt - l0), 32'd0);
        axi_read(5'h08, 32'h2, OKAY, "status still busy");
        p = 8'(ma) * 8'(mb);
        done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        axi_read(5'h08, 32'h1, OKAY, "status done");
        axi_read(5'h0C, 32'hE1, OKAY, "result 225");

        done = 1'b0;
        @(posedge clk); #1;
        axi_write(5'h00, 32'h2, 4'hF, OKAY, 1'b0, "restart");
        axi_read(5'h08, 32'h2, OKAY, "status restart");
        p = 8'h3C;
        axi_write(5'h08, 32'h1, 4'hF, OKAY, 1'b1, "w1c collide");
        axi_read(5'h08, 32'h1, OKAY, "status set wins");
        axi_read(5'h0C, 32'h3C, OKAY, "result second");
        axi_write(5'h08, 32'h1, 4'hF, OKAY, 1'b0, "w1c alone");
        axi_read(5'h08, 32'h0, OKAY, "status cleared");

        bready = 1'b0;
        awaddr = 5'h04; wdata = 32'h21; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        wait_ready(1'b0, "hold first");
        @(posedge clk); #1;
        wdata = 32'h43;
        for (int i = 0; i < 5; i++) begin
            check("hold bvalid", 32'(bvalid), 32'd1);
            check("hold no aw accept", 32'(awready), 32'd0);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        @(posedge clk); #1;
        check("bvalid drops", 32'(bvalid), 32'd0);
        check("aw after bresp", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        check("second bvalid", 32'(bvalid), 32'd1);
        @(posedge clk); #1;
        axi_read(5'h04, 32'h43, OKAY, "operand second write");

        bready = 1'b0; rready = 1'b0;
        awaddr = 5'h04; wdata = 32'h5A; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'h04; arvalid = 1'b1;
        #1;
        check("both accepted", 32'({awready, arready}), 32'h3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("pre-reset bvalid", 32'(bvalid), 32'd1);
        check("pre-reset rvalid", 32'(rvalid), 32'd1);
        check("read pre-write value", rdata, 32'h43);
        check("operand updated", 32'({b, a}), 32'h5A);
        rst_n = 1'b0;
        #1;
        check("mid reset handshakes", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
        check("mid reset pulses+operands", 32'({load, start, a, b}), 32'd0);
        check("mid reset rdata", rdata, 32'd0);
        check("mid reset resps", 32'({bresp, rresp}), 32'd0);
        #2;
        rst_n = 1'b1; bready = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no response after reset", 32'({bvalid, rvalid}), 32'd0);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
